// File: rtl/digitube_pkg.sv
// Shared types and constants for the 4-digit scanning display driver:
// FSM state encoding, blank values and the active-low hex segment table.
package digitube_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam logic [6:0]  SEG_BLANK  = 7'h7F;
    localparam logic [11:0] BLANK_WORD = 12'h0FF;

    // Segment order is {CG,CF,CE,CD,CC,CB,CA}; a 0 lights the segment.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/digitube_scan_driver_if.sv
// Bundle of the display-value inputs and scanned outputs of the digit-tube
// driver; master drives the value, slave is the driver itself.
interface digitube_scan_driver_if;
    import digitube_pkg::*;

    // en is a level, not a handshake: while high the driver scans and
    // re-samples data/dp_mask only at frame boundaries; while low it blanks.
    logic        en;
    logic [15:0] data;
    logic [3:0]  dp_mask;
    logic [11:0] digi_out;
    logic        frame_done;
    state_e      dbg_state;

    modport master (
        output en, data, dp_mask,
        input  digi_out, frame_done, dbg_state
    );

    modport slave (
        input  en, data, dp_mask,
        output digi_out, frame_done, dbg_state
    );

endinterface

// File: rtl/hex7seg_dec.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module hex7seg_dec
    import digitube_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/digitube_scan_driver.sv
// Time-multiplexed 4-digit hex display driver with registered 12-bit output.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module digitube_scan_driver
    import digitube_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    digitube_scan_driver_if.slave   bus
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] sh_data_q, sh_data_d;
    logic [3:0]  sh_dp_q, sh_dp_d;
    logic [11:0] digi_q, digi_d;
    logic        frame_done_q, frame_done_d;

    logic [3:0]  cur_digit;
    logic [6:0]  dec_seg;
    logic [6:0]  seg;
    logic        tick;

    assign cur_digit = sh_data_q[{idx_q, 2'b00} +: 4];
    assign tick      = (cnt_q == CNT_LAST);

    hex7seg_dec u_dec (
        .digit_i (cur_digit),
        .seg_o   (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // lz[k] is set when digit k and every digit above it are zero.
    logic [3:1] lz;
    always_comb begin
        lz[3] = (sh_data_q[15:12] == 4'h0);
        lz[2] = lz[3] && (sh_data_q[11:8] == 4'h0);
        lz[1] = lz[2] && (sh_data_q[7:4] == 4'h0);
        seg   = dec_seg;
        if (idx_q != 2'd0 && lz[idx_q]) begin
            seg = SEG_BLANK;
        end
    end
`else
    assign seg = dec_seg;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        sh_data_d    = sh_data_q;
        sh_dp_d      = sh_dp_q;
        frame_done_d = 1'b0;
        digi_d       = BLANK_WORD;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d   = SCAN;
                    sh_data_d = bus.data;
                    sh_dp_d   = bus.dp_mask;
                    idx_d     = 2'd0;
                    cnt_d     = '0;
                end
            end
            SCAN: begin
                digi_d = {4'b0001 << idx_q, ~sh_dp_q[idx_q], seg};
                // Disable wins over a pending tick: no pulse, no reload.
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end else if (tick) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        idx_d        = 2'd0;
                        sh_data_d    = bus.data;
                        sh_dp_d      = bus.dp_mask;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            sh_data_q    <= 16'h0000;
            sh_dp_q      <= 4'h0;
            digi_q       <= BLANK_WORD;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            digi_q       <= digi_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.digi_out   = digi_q;
    assign bus.frame_done = frame_done_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_digitube_scan_driver.sv
// Directed self-checking bench for digitube_scan_driver with CLK_DIV = 4.
// Leading-zero blanking vectors run only when LEADING_ZERO_BLANK_EN is defined.
module tb_digitube_scan_driver;
  import digitube_pkg::*;

  localparam int CLK_DIV = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  digitube_scan_driver_if dut_if ();

  digitube_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance n rising edges, then settle 1 time unit before sampling/driving
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input logic en, input logic [15:0] data, input logic [3:0] dp);
    dut_if.en      = en;
    dut_if.data    = data;
    dut_if.dp_mask = dp;
  endtask

  // Checks 16 consecutive cycles (one frame) starting at the current sample
  // point; optionally changes the inputs at cycle 5 (inside digit 1).
  task automatic check_frame(input string tag,
                             input logic [11:0] w0, input logic [11:0] w1,
                             input logic [11:0] w2, input logic [11:0] w3,
                             input bit chg, input logic [15:0] chg_data,
                             input logic [3:0] chg_dp);
    logic [11:0] words [4];
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_word%0d", tag, i), {4'h0, dut_if.digi_out}, {4'h0, words[i/4]});
      check($sformatf("%s_fdone%0d", tag, i), {15'h0, dut_if.frame_done}, {15'h0, (i == 15)});
      if (chg && i == 5) begin
        drive(1'b1, chg_data, chg_dp);
      end
      if (i != 15) step(1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(1'b0, 16'h0000, 4'h0);

    // 1: reset and idle
    reset = 1'b1;
    step(3);
    check("rst_digi", {4'h0, dut_if.digi_out}, 16'h00FF);
    check("rst_fdone", {15'h0, dut_if.frame_done}, 16'h0);
    check("rst_state", {15'h0, dut_if.dbg_state}, {15'h0, IDLE});
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("idle_digi", {4'h0, dut_if.digi_out}, 16'h00FF);
      check("idle_fdone", {15'h0, dut_if.frame_done}, 16'h0);
    end

    // 2: scan 1234, two frames; 3: change to ABCD inside digit 1 of frame 2
    drive(1'b1, 16'h1234, 4'h0);
    step(2);
    check_frame("f1234a", 12'h199, 12'h2B0, 12'h4A4, 12'h8F9, 1'b0, 16'h0, 4'h0);
    step(1);
    check_frame("f1234b", 12'h199, 12'h2B0, 12'h4A4, 12'h8F9, 1'b1, 16'hABCD, 4'b0100);
    step(1);
    check_frame("fabcd", 12'h1A1, 12'h2C6, 12'h403, 12'h888, 1'b0, 16'h0, 4'h0);

    // 4: drop en on the digit-2 tick cycle (idx=2, cnt=3 after 11 edges)
    for (int i = 0; i < 11; i++) begin
      step(1);
      check("pre_drop_fdone", {15'h0, dut_if.frame_done}, 16'h0);
    end
    drive(1'b0, 16'hABCD, 4'b0100);
    step(1);
    check("drop_fdone0", {15'h0, dut_if.frame_done}, 16'h0);
    check("drop_digi0", {4'h0, dut_if.digi_out}, 16'h0403);
    check("drop_state", {15'h0, dut_if.dbg_state}, {15'h0, IDLE});
    step(1);
    check("drop_fdone1", {15'h0, dut_if.frame_done}, 16'h0);
    check("drop_digi1", {4'h0, dut_if.digi_out}, 16'h00FF);
    drive(1'b1, 16'hE0F7, 4'b1001);
    step(2);
    check_frame("fe0f7", 12'h178, 12'h28E, 12'h4C0, 12'h806, 1'b0, 16'h0, 4'h0);

    // 5: reset mid digit 3 (idx=3, cnt=1 after 13 edges) with en held high
    step(13);
    check("pre_rst_digi", {4'h0, dut_if.digi_out}, 16'h0806);
    reset = 1'b1;
    step(1);
    check("midrst_digi", {4'h0, dut_if.digi_out}, 16'h00FF);
    check("midrst_fdone", {15'h0, dut_if.frame_done}, 16'h0);
    check("midrst_state", {15'h0, dut_if.dbg_state}, {15'h0, IDLE});
    reset = 1'b0;
    step(2);
    check_frame("fpostrst", 12'h178, 12'h28E, 12'h4C0, 12'h806, 1'b0, 16'h0, 4'h0);

`ifdef LEADING_ZERO_BLANK_EN
    // 6: leading-zero blanking
    drive(1'b0, 16'h0050, 4'h0);
    step(2);
    check("lz_blank", {4'h0, dut_if.digi_out}, 16'h00FF);
    drive(1'b1, 16'h0050, 4'h0);
    step(2);
    check_frame("lz0050", 12'h1C0, 12'h292, 12'h4FF, 12'h8FF, 1'b1, 16'h0000, 4'h0);
    step(1);
    check_frame("lz0000", 12'h1C0, 12'h2FF, 12'h4FF, 12'h8FF, 1'b0, 16'h0, 4'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
